// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction FIFO, instruction register and time-step counter
// that feed the datapath controller; reports retirement, stalls and step overflow.
module instr_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      in_instr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            IRin,
  input  logic            Clr,
  output logic [9:0]      INSTR,
  output logic [1:0]      T,
  output logic            stall,
  output logic            done,
  output logic [CNTW-1:0] retired,
  output logic            t_overflow
);

  localparam int              PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTRW:0]   FULL_CNT = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW:0]   CNT_ZERO = (PTRW+1)'(0);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
  localparam logic [PTRW-1:0] PTR_ZERO = PTRW'(0);
  localparam logic [CNTW-1:0] RET_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] RET_ZERO = CNTW'(0);

  typedef enum logic [1:0] {
    STEP0 = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2,
    STEP3 = 2'd3
  } step_t;

  logic [9:0]      r_mem [DEPTH];
  logic [PTRW-1:0] r_wptr;
  logic [PTRW-1:0] r_rptr;
  logic [PTRW:0]   r_count;
  step_t           r_step;
  step_t           w_step_nxt;
  logic [9:0]      r_instr;
  logic            r_done;
  logic [CNTW-1:0] r_retired;
  logic            r_tovf;
  logic            w_empty;
  logic            w_push;
  logic            w_load;
  logic            w_retire;
  logic            w_ovf;

  // A pop never frees space for a same-cycle push: ready looks at registered count only.
  assign w_empty  = (r_count == CNT_ZERO);
  assign in_ready = !rst && (r_count < FULL_CNT);
  assign w_push   = in_valid && in_ready;
  assign stall    = (r_step == STEP0) && IRin && w_empty;

  // Step state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= STEP0;
    end else begin
      r_step <= w_step_nxt;
    end
  end

  // Next step, load and retirement decisions.
  always_comb begin
    w_step_nxt = r_step;
    w_load     = 1'b0;
    w_retire   = 1'b0;
    w_ovf      = 1'b0;
    case (r_step)
      STEP0: begin
        if (IRin && !w_empty) begin
          w_load     = 1'b1;
          w_step_nxt = STEP1;
        end else begin
          w_step_nxt = STEP0;
        end
      end
      STEP1: begin
        if (Clr) begin
          w_retire   = 1'b1;
          w_step_nxt = STEP0;
        end else begin
          w_step_nxt = STEP2;
        end
      end
      STEP2: begin
        if (Clr) begin
          w_retire   = 1'b1;
          w_step_nxt = STEP0;
        end else begin
          w_step_nxt = STEP3;
        end
      end
      STEP3: begin
        w_retire   = 1'b1;
        w_step_nxt = STEP0;
        if (Clr) begin
          w_ovf = 1'b0;
        end else begin
          w_ovf = 1'b1;
        end
      end
      default: begin
        w_step_nxt = STEP0;
      end
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= PTR_ZERO;
      r_rptr  <= PTR_ZERO;
      r_count <= CNT_ZERO;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_load) r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_instr;
  end

  // Instruction register and retirement status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= 10'd0;
      r_done    <= 1'b0;
      r_retired <= RET_ZERO;
      r_tovf    <= 1'b0;
    end else begin
      if (w_load) r_instr <= r_mem[r_rptr];
      r_done <= w_retire;
      if (w_retire) r_retired <= r_retired + RET_ONE;
      if (w_ovf) r_tovf <= 1'b1;
    end
  end

  assign INSTR      = r_instr;
  assign T          = r_step;
  assign done       = r_done;
  assign retired    = r_retired;
  assign t_overflow = r_tovf;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios against constants
// plus a randomized run against a queue-based reference model.
module tb_instr_sequencer;

  localparam int DEPTH = 4;
  localparam int CNTW  = 2;

  localparam logic [9:0] W_LOAD = 10'b0001000000;
  localparam logic [9:0] W_COPY = 10'b0001100001;
  localparam logic [9:0] W_INV  = 10'b0001000100;
  localparam logic [9:0] W_ADDI = 10'b1001000101;

  logic            clk;
  logic            rst;
  logic [9:0]      in_instr;
  logic            in_valid;
  logic            in_ready;
  logic            IRin;
  logic            Clr;
  logic [9:0]      INSTR;
  logic [1:0]      T;
  logic            stall;
  logic            done;
  logic [CNTW-1:0] retired;
  logic            t_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [9:0] m_q[$];
  int         m_t;
  logic [9:0] m_instr;
  logic       m_done;
  int         m_ret;
  logic       m_ovf;
  logic       exp_ready, exp_stall, act_ready, act_stall;

  instr_sequencer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .IRin(IRin), .Clr(Clr), .INSTR(INSTR), .T(T),
    .stall(stall), .done(done), .retired(retired), .t_overflow(t_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, sample combinational outputs, clock, advance the model.
  task automatic tick(input logic v, input logic [9:0] d, input logic ir,
                      input logic cl, input logic r);
    logic push;
    in_valid = v; in_instr = d; IRin = ir; Clr = cl; rst = r;
    #1;
    exp_ready = !r && (m_q.size() < DEPTH);
    exp_stall = (m_t == 0) && ir && (m_q.size() == 0);
    act_ready = in_ready;
    act_stall = stall;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_t = 0; m_instr = 10'd0; m_done = 1'b0; m_ret = 0; m_ovf = 1'b0;
    end else begin
      push   = v && exp_ready;
      m_done = 1'b0;
      if (m_t == 0) begin
        if (ir && m_q.size() > 0) begin
          m_instr = m_q.pop_front();
          m_t = 1;
        end
      end else if (cl || m_t == 3) begin
        if (!cl) m_ovf = 1'b1;
        m_t = 0;
        m_done = 1'b1;
        m_ret = (m_ret + 1) % (1 << CNTW);
      end else begin
        m_t = m_t + 1;
      end
      if (push) m_q.push_back(d);
    end
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    tick(1'b1, 10'h155, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (act_ready !== 1'b0) $display("FAIL reset_ready_in_rst: got %b want 0", act_ready); else n_pass++;
    n_checks++; if (T !== 2'd0) $display("FAIL reset_T: got %0d want 0", T); else n_pass++;
    n_checks++; if (INSTR !== 10'd0) $display("FAIL reset_INSTR: got %h want 000", INSTR); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (retired !== 2'd0) $display("FAIL reset_retired: got %0d want 0", retired); else n_pass++;
    n_checks++; if (t_overflow !== 1'b0) $display("FAIL reset_tovf: got %b want 0", t_overflow); else n_pass++;
    tick(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (act_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", act_ready); else n_pass++;
  endtask

  task automatic test_fill();
    int accepted;
    accepted = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 10'($urandom), 1'b0, 1'b0, 1'b0);
      if (act_ready) accepted++;
      n_checks++;
      if (act_ready !== (i < 4)) $display("FAIL fill_ready[%0d]: got %b want %b", i, act_ready, (i < 4));
      else n_pass++;
    end
    n_checks++; if (accepted != 4) $display("FAIL fill_accepted: got %0d want 4", accepted); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 10'h101, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 10'h102, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 10'h103, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (T !== 2'd2) $display("FAIL rmid_T_before: got %0d want 2", T); else n_pass++;
    tick(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (T !== 2'd0) $display("FAIL rmid_T: got %0d want 0", T); else n_pass++;
    n_checks++; if (INSTR !== 10'd0) $display("FAIL rmid_INSTR: got %h want 000", INSTR); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rmid_done: got %b want 0", done); else n_pass++;
    n_checks++; if (retired !== 2'd0) $display("FAIL rmid_retired: got %0d want 0", retired); else n_pass++;
    tick(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (act_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", act_ready); else n_pass++;
    n_checks++; if (act_stall !== 1'b1) $display("FAIL rmid_empty_stall: got %b want 1", act_stall); else n_pass++;
    n_checks++; if (T !== 2'd0) $display("FAIL rmid_no_load: got %0d want 0", T); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_t [4]  = '{2'd1, 2'd0, 2'd1, 2'd0};
    logic       exp_d [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0] exp_i [4]  = '{W_LOAD, W_LOAD, W_COPY, W_COPY};
    logic [1:0] exp_r [4]  = '{2'd0, 2'd1, 2'd1, 2'd2};
    do_reset();
    tick(1'b1, W_LOAD, 1'b0, 1'b0, 1'b0);
    tick(1'b1, W_COPY, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 10'd0, 1'b1, 1'b1, 1'b0);
      n_checks++; if (T !== exp_t[i]) $display("FAIL b2b_T[%0d]: got %0d want %0d", i, T, exp_t[i]); else n_pass++;
      n_checks++; if (done !== exp_d[i]) $display("FAIL b2b_done[%0d]: got %b want %b", i, done, exp_d[i]); else n_pass++;
      n_checks++; if (INSTR !== exp_i[i]) $display("FAIL b2b_INSTR[%0d]: got %h want %h", i, INSTR, exp_i[i]); else n_pass++;
      n_checks++; if (retired !== exp_r[i]) $display("FAIL b2b_retired[%0d]: got %0d want %0d", i, retired, exp_r[i]); else n_pass++;
    end
  endtask

  task automatic test_mixed();
    logic       clr_s [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] exp_t [7] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_d [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    tick(1'b1, W_INV, 1'b0, 1'b0, 1'b0);
    tick(1'b1, W_ADDI, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 10'd0, 1'b1, clr_s[i], 1'b0);
      n_checks++; if (T !== exp_t[i]) $display("FAIL mixed_T[%0d]: got %0d want %0d", i, T, exp_t[i]); else n_pass++;
      n_checks++; if (done !== exp_d[i]) $display("FAIL mixed_done[%0d]: got %b want %b", i, done, exp_d[i]); else n_pass++;
      if (i == 0) begin
        n_checks++; if (INSTR !== W_INV) $display("FAIL mixed_INSTR_inv: got %h want %h", INSTR, W_INV); else n_pass++;
      end
      if (i == 3) begin
        n_checks++; if (INSTR !== W_ADDI) $display("FAIL mixed_INSTR_addi: got %h want %h", INSTR, W_ADDI); else n_pass++;
      end
    end
    n_checks++; if (retired !== 2'd2) $display("FAIL mixed_retired: got %0d want 2", retired); else n_pass++;
    n_checks++; if (t_overflow !== 1'b0) $display("FAIL mixed_tovf: got %b want 0", t_overflow); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (act_stall !== 1'b1) $display("FAIL stall_empty[%0d]: got %b want 1", i, act_stall); else n_pass++;
      n_checks++; if (T !== 2'd0) $display("FAIL stall_T[%0d]: got %0d want 0", i, T); else n_pass++;
    end
    tick(1'b1, 10'h2C7, 1'b1, 1'b0, 1'b0);
    n_checks++; if (act_stall !== 1'b1) $display("FAIL stall_push_cycle: got %b want 1", act_stall); else n_pass++;
    n_checks++; if (T !== 2'd0) $display("FAIL stall_no_bypass: got %0d want 0", T); else n_pass++;
    tick(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (act_stall !== 1'b0) $display("FAIL stall_released: got %b want 0", act_stall); else n_pass++;
    n_checks++; if (T !== 2'd1) $display("FAIL stall_load_T: got %0d want 1", T); else n_pass++;
    n_checks++; if (INSTR !== 10'h2C7) $display("FAIL stall_load_INSTR: got %h want 2c7", INSTR); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 10'(10'h040 + i), 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick((k == 2), 10'h3A5, 1'b1, 1'b0, 1'b0);
      n_checks++; if (T !== 2'(k % 4)) $display("FAIL ovf_T[%0d]: got %0d want %0d", k, T, k % 4); else n_pass++;
      n_checks++; if (done !== (k % 4 == 0)) $display("FAIL ovf_done[%0d]: got %b want %b", k, done, (k % 4 == 0)); else n_pass++;
      n_checks++; if (t_overflow !== (k >= 4)) $display("FAIL ovf_sticky[%0d]: got %b want %b", k, t_overflow, (k >= 4)); else n_pass++;
    end
    n_checks++; if (retired !== 2'd1) $display("FAIL ovf_retired_wrap: got %0d want 1", retired); else n_pass++;
    n_checks++; if (INSTR !== 10'h3A5) $display("FAIL ovf_INSTR5: got %h want 3a5", INSTR); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 10'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
      n_checks++; if (act_ready !== exp_ready) $display("FAIL rnd_ready[%0d]: got %b want %b", i, act_ready, exp_ready); else n_pass++;
      n_checks++; if (act_stall !== exp_stall) $display("FAIL rnd_stall[%0d]: got %b want %b", i, act_stall, exp_stall); else n_pass++;
      n_checks++; if (T !== 2'(m_t)) $display("FAIL rnd_T[%0d]: got %0d want %0d", i, T, m_t); else n_pass++;
      n_checks++; if (INSTR !== m_instr) $display("FAIL rnd_INSTR[%0d]: got %h want %h", i, INSTR, m_instr); else n_pass++;
      n_checks++; if (done !== m_done) $display("FAIL rnd_done[%0d]: got %b want %b", i, done, m_done); else n_pass++;
      n_checks++; if (retired !== CNTW'(m_ret)) $display("FAIL rnd_retired[%0d]: got %0d want %0d", i, retired, m_ret); else n_pass++;
      n_checks++; if (t_overflow !== m_ovf) $display("FAIL rnd_tovf[%0d]: got %b want %b", i, t_overflow, m_ovf); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 10'd0; IRin = 1'b0; Clr = 1'b0;
    m_t = 0; m_instr = 10'd0; m_done = 1'b0; m_ret = 0; m_ovf = 1'b0;
    test_reset();
    test_fill();
    test_reset_mid();
    test_back_to_back();
    test_mixed();
    test_stall();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Sits directly upstream of the datapath controller.
- Buffers incoming 10-bit instructions in a small FIFO, holds the instruction register, and generates the 2-bit time-step counter `T`.
- `T` and the latched instruction drive the controller's `INSTR`/`T` inputs. The controller's `IRin`/`Clr` outputs come back here to load the next instruction and restart the step count.
- Instruction completion and stall are reported to the surrounding system.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries, power of two, 2..16.
- `CNTW`, default 8: width of the retired-instruction counter.

Ports:
- `clk`  input  1  single system clock, all state on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_instr`  input  10  instruction word from program source.
- `in_valid`  input  1  `in_instr` is valid.
- `in_ready`  output  1  FIFO can accept a word this cycle.
- `IRin`  input  1  controller request to load the instruction register.
- `Clr`  input  1  controller request to end the instruction and return `T` to 0.
- `INSTR`  output  10  instruction register contents.
- `T`  output  2  current time step.
- `stall`  output  1  `T==0`, `IRin` high, FIFO empty.
- `done`  output  1  one-cycle pulse when an instruction retires.
- `retired`  output  CNTW  count of retired instructions, wraps.
- `t_overflow`  output  1  sticky: `T` wrapped from 3 without `Clr`.

## Operation

FIFO:
- Push when `in_valid && in_ready`.
- `in_ready = !rst && (count < DEPTH)`. A same-cycle pop does not raise `in_ready` while full.
- Pop when a load occurs (see below).
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, pointers both advance.
- Push into an empty FIFO is not visible to a pop until the next cycle. There is no bypass.
- Pointers wrap modulo `DEPTH`.

Step counter and instruction register, evaluated each cycle with priority top-down:
- `T==0`, `IRin`, FIFO non-empty: load. `INSTR <= head`, pop, `T <= 1`.
- `T==0`, otherwise: hold `T=0`, `INSTR` unchanged. `stall` is high if `IRin` is high.
- `T!=0`, `Clr`: `T <= 0`, `done <= 1`, `retired <= retired+1`.
- `T==3`, no `Clr`: `T <= 0`, `done <= 1`, `retired <= retired+1`, `t_overflow <= 1`.
- `T` in {1,2}, no `Clr`: `T <= T+1`.

Other rules:
- `IRin` is ignored when `T!=0`.
- `Clr` is ignored when `T==0`.
- `t_overflow` clears only on `rst`.
- `retired` wraps from 2^CNTW−1 to 0.

## Timing

- Reset values (on the `rst` cycle edge): `T=0`, `INSTR=0`, FIFO empty, `done=0`, `retired=0`, `t_overflow=0`. `in_ready` is 0 while `rst` is high and 1 the cycle after.
- Reset mid-instruction discards the FIFO contents and the in-flight instruction. No `done` is produced.
- `INSTR`, `T`, `done`, `retired`, and `t_overflow` are registered. `in_ready` and `stall` are combinational from registered state and `IRin`.
- Minimum push-to-`INSTR` latency is 2 cycles: push at edge N, load at edge N+1 (requires `T==0` and `IRin`).
- Instruction length is 2–4 cycles including `T=0`:
  - LOAD/COPY: `Clr` at `T=1`, 2 cycles.
  - INV/FLP: `Clr` at `T=2`, 3 cycles.
  - Others: `Clr` at `T=3`, 4 cycles.
- `done` is high the cycle `T` first reads 0 after retirement. A back-to-back load can occur that same cycle.
- Sustained throughput equals one instruction per instruction length with no bubbles, provided the FIFO is non-empty.

## Test plan

- Reset mid-instruction: push 3 words, assert `rst` at `T=2` -> next cycle `T=0`, `INSTR=0`, count 0, `in_ready=1`, `done=0`, `retired=0`.
- Fill/full: hold `in_valid` with no `IRin` for 6 cycles after reset -> exactly 4 pushes accepted, `in_ready=0` from the 5th cycle.
- Short instructions back to back: queue LOAD (`10'b0001000000`) then COPY (`10'b0001100001`), `IRin` at `T=0`, `Clr` at `T=1` -> `T` sequence 0,1,0,1,0. `done` pulses twice. `retired=2`. `INSTR` shows each word in order.
- Mixed lengths: queue INV (`10'b0001000100`) with `Clr` at `T=2`, then ADD-immediate (`10'b1001000101`) with `Clr` at `T=3` -> 3-cycle then 4-cycle instruction, `retired=2`, `t_overflow=0`.
- Empty stall: FIFO empty, `IRin` held high at `T=0` -> `stall=1`, `T` stays 0. Push one word -> `stall` remains 1 for the push cycle, load on the next edge, then `T=1`.
- Overflow and wrap: run with `Clr` never asserted -> `T` goes 1,2,3,0, `t_overflow=1` persists. With `CNTW=2`, retire 5 instructions -> `retired=1`.
